// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
// Latency: n/a (types only).
// Backpressure: n/a.
// Contents: fetch_entry_t (PC-tagged instruction), INSTR_BYTES (PC step per fetch).
package fetch_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/instr_fetch_if.sv
// Program memory read bus between program_memory (PROVIDER) and instr_fetch (CONSUMER).
// Latency: fixed; data_valid follows an accepted read_request by the memory latency.
// Backpressure: none; the consumer limits requests by its own credit.
// Signals: addr/read_request (consumer -> memory), instr/data_valid (memory -> consumer).
interface program_memory_bus;
   logic [31:0] addr;
   logic        read_request;
   logic [31:0] instr;
   logic        data_valid;

   modport CONSUMER (output addr, output read_request, input instr, input data_valid);
   modport PROVIDER (input addr, input read_request, output instr, output data_valid);
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of PC-tagged instructions with a registered head entry.
// Latency: a push into an empty FIFO is visible at the head one cycle later.
// Backpressure: head is held stable until popped; flush beats push; pushes beyond DEPTH are ignored.
// Ports: clk_i, rst_i (sync, active-high); push_i/push_dat_i; pop_i; flush_i;
//        head_dat_o/head_vld_o (registered head); count_o (current occupancy).
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 8
)(
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  fetch_entry_t           push_dat_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   output fetch_entry_t           head_dat_o,
   output logic                   head_vld_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int AW = $clog2(DEPTH);

   fetch_entry_t  mem_q [DEPTH];
   fetch_entry_t  head_q, head_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [AW:0]   remain;
   logic          do_pop, do_push;

   always_comb begin
      do_pop   = pop_i && (count_q != '0);
      remain   = count_q - (AW+1)'(do_pop);
      do_push  = push_i && (remain < (AW+1)'(DEPTH));
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      count_d  = remain + (AW+1)'(do_push);
      head_d   = head_q;
      // The head register always mirrors the entry at the next read pointer;
      // when the FIFO would otherwise be empty the incoming entry bypasses storage.
      if (remain == '0) begin
         if (do_push) begin
            head_d = push_dat_i;
         end
      end else begin
         head_d = mem_q[rd_ptr_d];
      end
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         head_d   = head_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) begin
         mem_q[wr_ptr_q] <= push_dat_i;
      end
   end

   assign head_dat_o = head_q;
   assign head_vld_o = (count_q != '0);
   assign count_o    = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: sequential PC fetch from program memory, PC tagging, buffering for decode.
// Latency: request to valid_out is MEM_LATENCY+1 cycles; redirect to new valid_out is MEM_LATENCY+2.
// Backpressure: ready_in low fills the FIFO; requests stop once buffered+in-flight reaches DEPTH.
// Ports: clk_in, rst_in (sync, active-high); mem (program_memory_bus.CONSUMER);
//        redirect_in/redirect_pc_in (flush and restart); instr_out/pc_out/valid_out/ready_in (decode side).
// Optional: INSTR_FETCH_PERF_EN adds fetched_count_out and flushed_count_out.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter int          DEPTH       = 8,
   parameter int          MEM_LATENCY = 2,
   parameter logic [31:0] RESET_PC    = 32'h0
)(
   input  logic                       clk_in,
   input  logic                       rst_in,
   program_memory_bus.CONSUMER        mem,
   input  logic                       redirect_in,
   input  logic [31:0]                redirect_pc_in,
   output logic [31:0]                instr_out,
   output logic [31:0]                pc_out,
   output logic                       valid_out,
   input  logic                       ready_in
`ifdef INSTR_FETCH_PERF_EN
   ,
   output logic [31:0]                fetched_count_out,
   output logic [31:0]                flushed_count_out
`endif
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [31:0]          fetch_pc_q, fetch_pc_d;
   logic [31:0]          addr_q, addr_d;
   logic                 read_request_q, read_request_d;
   // Stage 0 of the tag pipeline is the request on the bus (read_request_q/addr_q);
   // stages 1..MEM_LATENCY are held here, stage MEM_LATENCY lines up with data_valid.
   logic [MEM_LATENCY:1] tag_live_q, tag_live_d;
   logic [31:0]          tag_pc_q [1:MEM_LATENCY];
   logic [CW-1:0]        fifo_count;
   logic [31:0]          live_count;
   logic [31:0]          occupancy;
   logic                 credit_ok;
   logic                 push;
   logic                 pop;
   fetch_entry_t         push_dat;
   fetch_entry_t         head_dat;

   always_comb begin
      live_count = {31'b0, read_request_q};
      for (int k = 1; k <= MEM_LATENCY; k++) begin
         live_count = live_count + {31'b0, tag_live_q[k]};
      end
      // Same-cycle pops are deliberately not credited.
      occupancy = 32'(fifo_count) + live_count;
      credit_ok = (occupancy < 32'(DEPTH));
   end

   always_comb begin
      read_request_d = 1'b0;
      addr_d         = addr_q;
      fetch_pc_d     = fetch_pc_q;
      tag_live_d     = '0;
      if (redirect_in) begin
         fetch_pc_d = {redirect_pc_in[31:2], 2'b00};
      end else begin
         tag_live_d[1] = read_request_q;
         for (int k = 2; k <= MEM_LATENCY; k++) begin
            tag_live_d[k] = tag_live_q[k-1];
         end
         if (credit_ok) begin
            read_request_d = 1'b1;
            addr_d         = fetch_pc_q;
            fetch_pc_d     = fetch_pc_q + 32'(INSTR_BYTES);
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         fetch_pc_q     <= RESET_PC;
         addr_q         <= RESET_PC;
         read_request_q <= 1'b0;
         tag_live_q     <= '0;
      end else begin
         fetch_pc_q     <= fetch_pc_d;
         addr_q         <= addr_d;
         read_request_q <= read_request_d;
         tag_live_q     <= tag_live_d;
      end
   end

   // PC tags only matter while their live bit is set, so they need no reset.
   always_ff @(posedge clk_in) begin
      tag_pc_q[1] <= addr_q;
      for (int k = 2; k <= MEM_LATENCY; k++) begin
         tag_pc_q[k] <= tag_pc_q[k-1];
      end
   end

   assign mem.addr         = addr_q;
   assign mem.read_request = read_request_q;

   // Responses with a dead tag (flushed or pre-reset) are dropped here.
   assign push           = mem.data_valid && tag_live_q[MEM_LATENCY] && !redirect_in;
   assign push_dat.pc    = tag_pc_q[MEM_LATENCY];
   assign push_dat.instr = mem.instr;
   assign pop            = valid_out && ready_in;

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i      (clk_in),
      .rst_i      (rst_in),
      .push_i     (push),
      .push_dat_i (push_dat),
      .pop_i      (pop),
      .flush_i    (redirect_in),
      .head_dat_o (head_dat),
      .head_vld_o (valid_out),
      .count_o    (fifo_count)
   );

   assign instr_out = head_dat.instr;
   assign pc_out    = head_dat.pc;

`ifdef INSTR_FETCH_PERF_EN
   logic [31:0] fetched_q, fetched_d;
   logic [31:0] flushed_q, flushed_d;

   always_comb begin
      fetched_d = fetched_q;
      flushed_d = flushed_q;
      if (push) begin
         fetched_d = fetched_q + 32'd1;
      end
      // Everything buffered or in flight at the redirect edge is discarded.
      if (redirect_in) begin
         flushed_d = flushed_q + occupancy;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         fetched_q <= '0;
         flushed_q <= '0;
      end else begin
         fetched_q <= fetched_d;
         flushed_q <= flushed_d;
      end
   end

   assign fetched_count_out = fetched_q;
   assign flushed_count_out = flushed_q;
`endif

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch front-end, directly downstream of `program_memory`. It drives the `CONSUMER` side of `program_memory_bus` and issues sequential word fetches from a program counter. It tags each fixed-latency response with its PC and buffers it in a small FIFO for the decode stage. A redirect (branch/jump) flushes buffered and in-flight instructions and restarts fetch at a new PC.

## Interface
- `DEPTH`, default 8: FIFO entries; power of two, ≥ 2.
- `MEM_LATENCY`, default 2: cycles from `read_request` sampled to `data_valid`; must match `program_memory`.
- `RESET_PC`, default 32'h0: first fetch address after reset.
- `clk_in` input 1: single clock.
- `rst_in` input 1: reset, synchronous, active-high; driven by `program_memory.sys_rst_out` at top level.
- `mem` interface `program_memory_bus.CONSUMER`: drives `addr` and `read_request`; receives `instr` and `data_valid`.
- `redirect_in` input 1: flush and restart at `redirect_pc_in`.
- `redirect_pc_in` input 32: new PC; bits [1:0] ignored and treated as 0.
- `instr_out` output 32: instruction at FIFO head.
- `pc_out` output 32: PC of `instr_out`.
- `valid_out` output 1: FIFO head valid.
- `ready_in` input 1: decode accepts head when `valid_out && ready_in`.

## Operation
- **Registers:** `fetch_pc`; `mem.addr` and `mem.read_request` are registered outputs. There is no combinational path from `ready_in` or `redirect_in` to `mem.*`.
- **Tag pipeline:** shift register of MEM_LATENCY+1 stages, each holding {live, pc}. Stage 0 mirrors the request currently presented. Stage MEM_LATENCY coincides with `mem.data_valid`.
- **live_count:** number of live stages.
- **Issue rule (evaluated each edge):**
  - If `fifo_count + live_count < DEPTH` and no redirect: next cycle presents `addr = fetch_pc`, `read_request = 1`, and `fetch_pc += 4`, wrapping modulo 2^32.
  - Otherwise `read_request = 0`.
  - Pops in the same cycle are not credited (conservative).
- **Response write:** when `mem.data_valid` is high and stage MEM_LATENCY is live, push {instr, pc} into the FIFO.
  - `data_valid` with a dead tag is dropped silently.
  - By the credit rule the FIFO never overflows.
- **Redirect:** at the edge where `redirect_in` is high:
  - clear all live bits and empty the FIFO (`valid_out` low next cycle);
  - set `read_request = 0` and `fetch_pc = {redirect_pc_in[31:2], 2'b00}`.
  - The first new request is presented the cycle after.
- **Simultaneous pop and redirect:** the head counts as consumed; the flush still applies.
- **Simultaneous push and redirect:** the push is discarded.
- **Reset mid-operation:** all state returns to reset values; responses to pre-reset requests carry dead tags and are dropped.

## Timing
- **Reset values:** `read_request` 0, `addr` RESET_PC, `valid_out` 0, `instr_out` 0, `pc_out` 0, FIFO empty, all tags dead, `fetch_pc` RESET_PC.
- **First edge with `rst_in` low (E0):** `read_request` = 1 after E0.
- **Response:** `data_valid` high after E(MEM_LATENCY). Written at E(MEM_LATENCY+1). `valid_out` high after that edge.
- **Latency:** request-to-`valid_out` is MEM_LATENCY+1 cycles; reset-release-to-first-instruction is MEM_LATENCY+2 edges.
- **Throughput:** sustained 1 instruction/cycle with `ready_in` held high requires DEPTH ≥ MEM_LATENCY+3.
- **Redirect penalty:** `redirect_in` at edge R → new request after R+1 → `valid_out` after R+1+MEM_LATENCY+1.
- **FIFO:** registered output; `instr_out`/`pc_out` are stable while `valid_out && !ready_in`.

## Configuration
- **`INSTR_FETCH_PERF_EN` defined:** adds output ports `fetched_count_out` [31:0] and `flushed_count_out` [31:0], both reset to 0 and wrapping.
  - `fetched_count_out` increments on each FIFO push.
  - `flushed_count_out` increments on each redirect by `fifo_count + live_count`, where each term is counted before the flush.
- **Undefined:** ports and counters are absent; behaviour is otherwise identical.

## Structure
- **Shared package `fetch_pkg`:** `typedef struct packed { logic [31:0] pc; logic [31:0] instr; } fetch_entry_t`; `localparam INSTR_BYTES = 4`.
- **Sub-module `fetch_fifo`:** synchronous FIFO with parameter DEPTH, push/pop/flush, registered head, and `count` output. Flush has priority over push.
- The tag pipeline and issue logic live in `instr_fetch`.

## Test plan
- **Reset release**, memory model returning `instr = addr ^ 32'hA5A5_0000`:
  - first request `addr = 0` after E0;
  - `valid_out` after E3 with `pc_out = 0`, `instr_out = 32'hA5A5_0000`.
- **`ready_in` held high:** PCs 0, 4, 8, … appear on consecutive cycles with no bubble after warm-up (DEPTH = 8).
- **Backpressure:** hold `ready_in = 0` for 20 cycles.
  - `read_request` stops once `fifo_count + live_count = 8`.
  - No entry is lost or duplicated.
  - Resuming yields contiguous PCs.
- **Redirect with the pipeline full:** `redirect_pc_in = 32'h0000_1003`.
  - In-flight responses are dropped.
  - Next `pc_out` is `32'h0000_1000`, appearing 4 cycles after the redirect edge.
- **Redirect and pop in the same cycle:** the popped entry is consumed once and no stale entry appears afterward. Covers PC wrap from `32'hFFFF_FFFC` to 0.
- **With `INSTR_FETCH_PERF_EN`:**
  - after 10 pushes, `fetched_count_out = 10`;
  - a redirect with 5 buffered entries and 3 live tags makes `flushed_count_out = 8`.
